// File: rtl/reg_file_rename_pkg.sv
// Shared constants for the architectural register file / rename-tag table.
// Optional same-cycle commit forwarding is enabled by defining REGFILE_BYPASS_EN.
package reg_file_rename_pkg;

    localparam int ROB_BITS  = 4;
    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    typedef logic [REG_IDX_W-1:0] regIdx_t;
    typedef logic [ROB_BITS-1:0]  robTag_t;
    typedef logic [XLEN-1:0]      regVal_t;

endpackage

// File: rtl/reg_file_rename_read_port.sv
// One source-operand read port: x0 masking plus, when REGFILE_BYPASS_EN is
// defined, forwarding of the commit happening in the same cycle.
module reg_file_rename_read_port
    import reg_file_rename_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs_i,
    input  logic [XLEN-1:0]      reg_value_i,
    input  logic                 reg_busy_i,
    input  logic [ROB_BITS-1:0]  reg_tag_i,
    input  logic [REG_IDX_W-1:0] commit_rd_i,
    input  logic [XLEN-1:0]      commit_value_i,
    input  logic [REG_IDX_W-1:0] commit_clr_rd_i,
    input  logic [ROB_BITS-1:0]  commit_tag_i,
    input  logic                 bypass_ok_i,
    output logic [XLEN-1:0]      value_o,
    output logic                 busy_o,
    output logic [ROB_BITS-1:0]  tag_o
);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        value_o = reg_value_i;
        busy_o  = reg_busy_i;
        tag_o   = reg_tag_i;
        if (rs_i == '0) begin
            value_o = '0;
            busy_o  = 1'b0;
            tag_o   = '0;
        end else if (bypass_ok_i && (rs_i == commit_rd_i)) begin
            value_o = commit_value_i;
            // The producer is retiring now, so the operand is ready this cycle.
            if ((commit_clr_rd_i == rs_i) && reg_busy_i && (reg_tag_i == commit_tag_i)) begin
                busy_o = 1'b0;
            end
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{commit_rd_i, commit_value_i, commit_clr_rd_i, commit_tag_i, bypass_ok_i};

    always_comb begin
        value_o = reg_value_i;
        busy_o  = reg_busy_i;
        tag_o   = reg_tag_i;
        if (rs_i == '0) begin
            value_o = '0;
            busy_o  = 1'b0;
            tag_o   = '0;
        end
    end
`endif

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags (busy + RoB id).
// Define REGFILE_BYPASS_EN to forward the current commit to the read ports.
module reg_file_rename
    import reg_file_rename_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rob_clear,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [ROB_BITS-1:0]  issue_tag,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [XLEN-1:0]      commit_value,
    input  logic [REG_IDX_W-1:0] commit_clr_rd,
    input  logic [ROB_BITS-1:0]  commit_tag,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic [XLEN-1:0]      rs1_value,
    output logic                 rs1_busy,
    output logic [ROB_BITS-1:0]  rs1_tag,
    output logic [XLEN-1:0]      rs2_value,
    output logic                 rs2_busy,
    output logic [ROB_BITS-1:0]  rs2_tag
);

    logic [XLEN-1:0]     value_q [REG_NUM];
    logic [XLEN-1:0]     value_d [REG_NUM];
    logic [REG_NUM-1:0]  busy_q;
    logic [REG_NUM-1:0]  busy_d;
    logic [ROB_BITS-1:0] tag_q   [REG_NUM];
    logic [ROB_BITS-1:0] tag_d   [REG_NUM];
    logic                bypassOk;

    // Entry 0 is never updated, so it holds its reset value of zero forever.
    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        for (int i = 1; i < REG_NUM; i++) begin
            if (commit_rd == REG_IDX_W'(i)) begin
                value_d[i] = commit_value;
            end
            if (rob_clear) begin
                busy_d[i] = 1'b0;
            end else begin
                if ((commit_clr_rd == REG_IDX_W'(i)) && busy_q[i] && (tag_q[i] == commit_tag)) begin
                    busy_d[i] = 1'b0;
                end
                if (issue_rd == REG_IDX_W'(i)) begin
                    busy_d[i] = 1'b1;
                    tag_d[i]  = issue_tag;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else if (rdy_in) begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    assign bypassOk = !rst_in && rdy_in;

    reg_file_rename_read_port u_read_rs1 (
        .rs_i           (rs1),
        .reg_value_i    (value_q[rs1]),
        .reg_busy_i     (busy_q[rs1]),
        .reg_tag_i      (tag_q[rs1]),
        .commit_rd_i    (commit_rd),
        .commit_value_i (commit_value),
        .commit_clr_rd_i(commit_clr_rd),
        .commit_tag_i   (commit_tag),
        .bypass_ok_i    (bypassOk),
        .value_o        (rs1_value),
        .busy_o         (rs1_busy),
        .tag_o          (rs1_tag)
    );

    reg_file_rename_read_port u_read_rs2 (
        .rs_i           (rs2),
        .reg_value_i    (value_q[rs2]),
        .reg_busy_i     (busy_q[rs2]),
        .reg_tag_i      (tag_q[rs2]),
        .commit_rd_i    (commit_rd),
        .commit_value_i (commit_value),
        .commit_clr_rd_i(commit_clr_rd),
        .commit_tag_i   (commit_tag),
        .bypass_ok_i    (bypassOk),
        .value_o        (rs2_value),
        .busy_o         (rs2_busy),
        .tag_o          (rs2_tag)
    );

endmodule

// File: tb/tb_reg_file_rename.sv
// Self-checking bench for reg_file_rename: directed vectors, a per-cycle
// reference model comparison, and hand-computed literal expectations.
module tb_reg_file_rename;
    import reg_file_rename_pkg::*;

    logic                 clk = 1'b0;
    logic                 rstIn = 1'b1;
    logic                 rdyIn = 1'b1;
    logic                 robClear = 1'b0;
    logic [REG_IDX_W-1:0] issueRd = '0;
    logic [ROB_BITS-1:0]  issueTag = '0;
    logic [REG_IDX_W-1:0] commitRd = '0;
    logic [XLEN-1:0]      commitValue = '0;
    logic [REG_IDX_W-1:0] commitClrRd = '0;
    logic [ROB_BITS-1:0]  commitTag = '0;
    logic [REG_IDX_W-1:0] rs1 = '0;
    logic [REG_IDX_W-1:0] rs2 = '0;
    logic [XLEN-1:0]      rs1Value, rs2Value;
    logic                 rs1Busy, rs2Busy;
    logic [ROB_BITS-1:0]  rs1Tag, rs2Tag;

    int checkCount = 0;
    int passCount  = 0;
    bit checkEn    = 1'b0;

    logic [XLEN-1:0]     mVal  [REG_NUM];
    logic                mBusy [REG_NUM];
    logic [ROB_BITS-1:0] mTag  [REG_NUM];

    always #5 clk = ~clk;

    reg_file_rename dut (
        .clk_in       (clk),
        .rst_in       (rstIn),
        .rdy_in       (rdyIn),
        .rob_clear    (robClear),
        .issue_rd     (issueRd),
        .issue_tag    (issueTag),
        .commit_rd    (commitRd),
        .commit_value (commitValue),
        .commit_clr_rd(commitClrRd),
        .commit_tag   (commitTag),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_value    (rs1Value),
        .rs1_busy     (rs1Busy),
        .rs1_tag      (rs1Tag),
        .rs2_value    (rs2Value),
        .rs2_busy     (rs2Busy),
        .rs2_tag      (rs2Tag)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic [4:0] iRd, input logic [3:0] iTag,
                                 input logic [4:0] cRd, input logic [31:0] cVal,
                                 input logic [4:0] cClr, input logic [3:0] cTag,
                                 input logic clr, input logic [4:0] r1, input logic [4:0] r2);
        issueRd = iRd; issueTag = iTag;
        commitRd = cRd; commitValue = cVal;
        commitClrRd = cClr; commitTag = cTag;
        robClear = clr; rs1 = r1; rs2 = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: register state updated from the architectural rules.
    initial begin
        for (int i = 0; i < REG_NUM; i++) begin
            mVal[i] = '0; mBusy[i] = 1'b0; mTag[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (rstIn) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mVal[i] = '0; mBusy[i] = 1'b0; mTag[i] = '0;
            end
        end else if (rdyIn) begin
            if (commitRd != 0) mVal[commitRd] = commitValue;
            if (robClear) begin
                for (int i = 0; i < REG_NUM; i++) mBusy[i] = 1'b0;
            end else begin
                if (commitClrRd != 0 && mBusy[commitClrRd] && mTag[commitClrRd] == commitTag)
                    mBusy[commitClrRd] = 1'b0;
                if (issueRd != 0) begin
                    mBusy[issueRd] = 1'b1;
                    mTag[issueRd]  = issueTag;
                end
            end
        end
    end

    function automatic logic [31:0] expValue(input logic [4:0] rs);
        logic [31:0] v;
        v = (rs == 0) ? 32'h0 : mVal[rs];
`ifdef REGFILE_BYPASS_EN
        if (!rstIn && rdyIn && rs != 0 && rs == commitRd) v = commitValue;
`endif
        return v;
    endfunction

    function automatic logic expBusy(input logic [4:0] rs);
        logic b;
        b = (rs == 0) ? 1'b0 : mBusy[rs];
`ifdef REGFILE_BYPASS_EN
        if (!rstIn && rdyIn && rs != 0 && rs == commitRd && commitClrRd == rs && mBusy[rs] && mTag[rs] == commitTag)
            b = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic [3:0] expTag(input logic [4:0] rs);
        return (rs == 0) ? 4'h0 : mTag[rs];
    endfunction

    // Every cycle once reset has taken effect, both read ports must match the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model rs1_value", rs1Value, expValue(rs1));
            checkOutput("model rs1_busy", {31'b0, rs1Busy}, {31'b0, expBusy(rs1)});
            checkOutput("model rs1_tag", {28'b0, rs1Tag}, {28'b0, expTag(rs1)});
            checkOutput("model rs2_value", rs2Value, expValue(rs2));
            checkOutput("model rs2_busy", {31'b0, rs2Busy}, {31'b0, expBusy(rs2)});
            checkOutput("model rs2_tag", {28'b0, rs2Tag}, {28'b0, expTag(rs2)});
        end
    end

    initial begin
        // Reset
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
        rstIn = 1'b1;
        tick();
        checkEn = 1'b1;
        tick();
        rstIn = 1'b0;
        #1;
        checkOutput("reset rs1_value", rs1Value, 32'h0);
        checkOutput("reset rs1_busy", {31'b0, rs1Busy}, 32'h0);
        checkOutput("reset rs1_tag", {28'b0, rs1Tag}, 32'h0);
        checkOutput("reset rs2_value", rs2Value, 32'h0);
        checkOutput("reset rs2_busy", {31'b0, rs2Busy}, 32'h0);
        checkOutput("reset rs2_tag", {28'b0, rs2Tag}, 32'h0);

        // Issue x3 tag 2, then commit it
        applyStimulus(3, 2, 0, 0, 0, 0, 0, 3, 0);
        #1;
        checkOutput("same-cycle old mapping busy", {31'b0, rs1Busy}, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0);
        #1;
        checkOutput("issued busy", {31'b0, rs1Busy}, 32'h1);
        checkOutput("issued tag", {28'b0, rs1Tag}, 32'h2);
        applyStimulus(0, 0, 3, 32'h1234, 3, 2, 0, 3, 0);
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("bypass value", rs1Value, 32'h1234);
        checkOutput("bypass busy", {31'b0, rs1Busy}, 32'h0);
`else
        checkOutput("no-bypass value", rs1Value, 32'h0);
        checkOutput("no-bypass busy", {31'b0, rs1Busy}, 32'h1);
`endif
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0);
        #1;
        checkOutput("committed value", rs1Value, 32'h1234);
        checkOutput("committed busy", {31'b0, rs1Busy}, 32'h0);

        // Younger renamer survives an older commit
        applyStimulus(4, 1, 0, 0, 0, 0, 0, 4, 3);
        tick();
        applyStimulus(4, 5, 0, 0, 0, 0, 0, 4, 3);
        tick();
        applyStimulus(0, 0, 4, 32'hABCD, 4, 1, 0, 4, 3);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 4, 3);
        #1;
        checkOutput("stale commit value", rs1Value, 32'hABCD);
        checkOutput("stale commit busy", {31'b0, rs1Busy}, 32'h1);
        checkOutput("stale commit tag", {28'b0, rs1Tag}, 32'h5);

        // Issue wins over release on the same register
        applyStimulus(7, 3, 0, 0, 0, 0, 0, 7, 0);
        tick();
        applyStimulus(7, 6, 0, 0, 7, 3, 0, 7, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 0);
        #1;
        checkOutput("issue beats release busy", {31'b0, rs1Busy}, 32'h1);
        checkOutput("issue beats release tag", {28'b0, rs1Tag}, 32'h6);

        // rob_clear drops every tag but still writes the committed value
        applyStimulus(1, 8, 0, 0, 0, 0, 0, 1, 2);
        tick();
        applyStimulus(2, 9, 0, 0, 0, 0, 0, 1, 2);
        tick();
        applyStimulus(9, 10, 0, 0, 0, 0, 0, 9, 2);
        tick();
        applyStimulus(10, 11, 1, 32'h80, 0, 0, 1, 9, 10);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9);
        #1;
        checkOutput("clear value x1", rs1Value, 32'h80);
        checkOutput("clear busy x1", {31'b0, rs1Busy}, 32'h0);
        checkOutput("clear busy x9", {31'b0, rs2Busy}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 10, 2);
        #1;
        checkOutput("clear drops issue x10", {31'b0, rs1Busy}, 32'h0);
        checkOutput("clear busy x2", {31'b0, rs2Busy}, 32'h0);
        tick();

        // x0 ignores writes and renames
        applyStimulus(0, 4, 0, 32'hFFFF, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("x0 value", rs1Value, 32'h0);
        checkOutput("x0 busy", {31'b0, rs1Busy}, 32'h0);
        checkOutput("x0 tag", {28'b0, rs1Tag}, 32'h0);

        // rdy low freezes state
        rdyIn = 1'b0;
        applyStimulus(12, 7, 12, 32'h55, 0, 0, 0, 12, 3);
        #1;
        checkOutput("rdy low no bypass", rs1Value, 32'h0);
        tick();
        rdyIn = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 12, 3);
        #1;
        checkOutput("rdy low value", rs1Value, 32'h0);
        checkOutput("rdy low busy", {31'b0, rs1Busy}, 32'h0);
        checkOutput("rdy low keeps x3", rs2Value, 32'h1234);
        tick();

        // Reset beats a simultaneous commit and issue
        applyStimulus(6, 3, 5, 32'h99, 0, 0, 0, 5, 4);
        rstIn = 1'b1;
        tick();
        rstIn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 4);
        #1;
        checkOutput("reset beats commit", rs1Value, 32'h0);
        checkOutput("reset clears busy", {31'b0, rs2Busy}, 32'h0);
        checkOutput("reset clears tag", {28'b0, rs2Tag}, 32'h0);
        tick();
        tick();

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
